// File: rtl/axi_slave_ram.sv
// AXI3-style slave with a word-addressed internal RAM. Read and write channels run
// as independent single-outstanding-burst FSMs; INCR bursts only, index wraps at MEM_WORDS.
module axi_slave_ram #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the slave holds valid and its payload stable until the master raises ready.
  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e         r_state_q, r_state_d;
  logic [3:0]       r_id_q, r_id_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]       r_cnt_q, r_cnt_d;
  logic             r_err_q, r_err_d;

  w_state_e         w_state_q, w_state_d;
  logic [3:0]       w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic             w_err_q, w_err_d;

  logic [31:0] mem [MEM_WORDS];
  logic        mem_we;
  logic        unused_bits;

  // Address bits outside the word index alias; write IDs are not tracked.
  assign unused_bits = ^{wid, araddr[31:IDX_W+2], araddr[1:0],
                         awaddr[31:IDX_W+2], awaddr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // Memory is never reset; a same-cycle read sees the value before this edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    if (!reset) begin
      case (r_state_q)
        R_IDLE: begin
          arready = 1'b1;
          if (arvalid) begin
            r_id_d    = arid;
            r_idx_d   = araddr[IDX_W+1:2];
            r_cnt_d   = arlen;
            r_err_d   = (arsize > 3'd2);
            r_state_d = R_BURST;
          end
        end
        R_BURST: begin
          rvalid = 1'b1;
          if (rready) begin
            r_idx_d = r_idx_q + IDX_W'(1);
            r_cnt_d = r_cnt_q - 8'd1;
            if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  assign rid   = rvalid ? r_id_q : 4'd0;
  assign rdata = rvalid ? mem[r_idx_q] : 32'd0;
  assign rresp = (rvalid && r_err_q) ? 2'b10 : 2'b00;
  assign rlast = rvalid && (r_cnt_q == 8'd0);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    if (!reset) begin
      case (w_state_q)
        W_IDLE: begin
          awready = 1'b1;
          if (awvalid) begin
            w_id_d    = awid;
            w_idx_d   = awaddr[IDX_W+1:2];
            w_cnt_d   = awlen;
            w_err_d   = (awsize > 3'd2);
            w_state_d = W_DATA;
          end
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            w_idx_d = w_idx_q + IDX_W'(1);
            w_cnt_d = w_cnt_q - 8'd1;
            // The burst length comes from awlen; a misplaced wlast only flags an error.
            if (wlast != (w_cnt_q == 8'd0)) w_err_d = 1'b1;
            if (w_cnt_q == 8'd0) w_state_d = W_RESP;
          end
        end
        W_RESP: begin
          bvalid = 1'b1;
          if (bready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  assign mem_we = wready && wvalid && !w_err_q;
  assign bid    = bvalid ? w_id_q : 4'd0;
  assign bresp  = (bvalid && w_err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: inputs change on the falling edge, outputs are
// sampled on the falling edge, read data is scored against an expected queue.
module tb_axi_slave_ram;
  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  axi_slave_ram #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks: each starts just after a falling edge and returns just after one.
  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL w_timeout: wready=%b required 1", wready);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(output logic [3:0] id, output logic [1:0] resp, output logic seen);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    seen = bvalid; id = bid; resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Scoreboard: drains exp_q, optionally toggling rready every cycle.
  task automatic read_check(input logic [3:0] id, input logic [1:0] resp, input bit toggle);
    int cyc = 0;
    rready = 1'b1;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (rvalid) begin
        checks++;
        if (rdata !== exp_q[0]) begin
          errors++;
          $display("FAIL rdata: got %h required %h", rdata, exp_q[0]);
        end
        checks++;
        if ({rid, rresp, rlast} !== {id, resp, exp_q.size() == 1}) begin
          errors++;
          $display("FAIL r_ctrl: rid/rresp/rlast got %h/%b/%b required %h/%b/%b",
                   rid, rresp, rlast, id, resp, exp_q.size() == 1);
        end
        if (rready) void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
      if (toggle) rready = ~rready;
    end
    rready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL r_end: beats left %0d rvalid=%b arready=%b required 0/0/1",
               exp_q.size(), rvalid, arready);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/aw/w/rv/bv/rlast got %b required 000000",
               {arready, awready, wready, rvalid, bvalid, rlast});
    end
    checks++;
    if ({rresp, bresp, rid, bid, rdata} !== 44'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h required 0", {rresp, bresp, rid, bid, rdata});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({arready, awready, wready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: ar/aw/w got %b required 110", {arready, awready, wready});
    end
  endtask

  task automatic test_basic;
    logic [3:0] id; logic [1:0] resp; logic seen;
    aw_send(4'd5, 32'h10, 8'd3, 3'd2);
    for (int k = 0; k < 4; k++) w_beat(32'hA0 + k, 4'hF, k == 3);
    b_take(id, resp, seen);
    checks++;
    if ({seen, id, resp} !== {1'b1, 4'd5, 2'b00}) begin
      errors++;
      $display("FAIL basic_b: bvalid/bid/bresp got %b/%h/%b required 1/5/00", seen, id, resp);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + k);
    ar_send(4'd3, 32'h10, 8'd3, 3'd2);
    read_check(4'd3, 2'b00, 1'b0);
  endtask

  task automatic test_strobe;
    logic [3:0] id; logic [1:0] resp; logic seen;
    aw_send(4'd1, 32'h40, 8'd0, 3'd2);
    w_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    b_take(id, resp, seen);
    checks++;
    if ({seen, id, resp} !== {1'b1, 4'd1, 2'b00}) begin
      errors++;
      $display("FAIL strobe_b1: got %b/%h/%b required 1/1/00", seen, id, resp);
    end
    aw_send(4'd2, 32'h40, 8'd0, 3'd2);
    w_beat(32'h1122_3344, 4'b0101, 1'b1);
    b_take(id, resp, seen);
    checks++;
    if ({seen, id, resp} !== {1'b1, 4'd2, 2'b00}) begin
      errors++;
      $display("FAIL strobe_b2: got %b/%h/%b required 1/2/00", seen, id, resp);
    end
    exp_q.push_back(32'hFF22_FF44);
    ar_send(4'd2, 32'h40, 8'd0, 3'd2);
    read_check(4'd2, 2'b00, 1'b0);
  endtask

  task automatic test_stall;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + k);
    ar_send(4'd6, 32'h10, 8'd3, 3'd2);
    read_check(4'd6, 2'b00, 1'b1);
  endtask

  task automatic test_errors;
    logic [3:0] id; logic [1:0] resp; logic seen;
    aw_send(4'd9, 32'h80, 8'd1, 3'd2);
    w_beat(32'h55, 4'hF, 1'b1);
    checks++;
    if ({wready, bvalid} !== 2'b10) begin
      errors++;
      $display("FAIL early_wlast: wready/bvalid got %b required 10", {wready, bvalid});
    end
    w_beat(32'h66, 4'hF, 1'b0);
    b_take(id, resp, seen);
    checks++;
    if ({seen, id, resp} !== {1'b1, 4'd9, 2'b10}) begin
      errors++;
      $display("FAIL wlast_err_b: got %b/%h/%b required 1/9/10", seen, id, resp);
    end
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hA1);
    ar_send(4'd4, 32'h10, 8'd1, 3'd3);
    read_check(4'd4, 2'b10, 1'b0);
  endtask

  task automatic test_wrap;
    logic [3:0] id; logic [1:0] resp; logic seen;
    aw_send(4'd1, 32'hFF8, 8'd7, 3'd2);
    for (int k = 0; k < 8; k++) w_beat(32'hB0 + k, 4'hF, k == 7);
    b_take(id, resp, seen);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hB0 + k);
    ar_send(4'd2, 32'hFF8, 8'd7, 3'd2);
    read_check(4'd2, 2'b00, 1'b0);
    // Lock-step read and write of the same words: reads see the old contents.
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hB0 + k);
    fork
      begin
        aw_send(4'd7, 32'hFF8, 8'd7, 3'd2);
        for (int k = 0; k < 8; k++) w_beat(32'hC0 + k, 4'hF, k == 7);
      end
      begin
        ar_send(4'd8, 32'hFF8, 8'd7, 3'd2);
        read_check(4'd8, 2'b00, 1'b0);
      end
    join
    b_take(id, resp, seen);
    checks++;
    if ({seen, id, resp} !== {1'b1, 4'd7, 2'b00}) begin
      errors++;
      $display("FAIL wrap_b: got %b/%h/%b required 1/7/00", seen, id, resp);
    end
    // Read trailing the write by one cycle: each word is seen with its new value.
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hD0 + k);
    fork
      begin
        aw_send(4'd3, 32'hFF8, 8'd7, 3'd2);
        for (int k = 0; k < 8; k++) w_beat(32'hD0 + k, 4'hF, k == 7);
      end
      begin
        @(negedge clk);
        ar_send(4'd9, 32'hFF8, 8'd7, 3'd2);
        read_check(4'd9, 2'b00, 1'b0);
      end
    join
    b_take(id, resp, seen);
    // Index 0 holds beat 2 of the wrapped burst; upper address bits alias.
    exp_q.push_back(32'hD2);
    ar_send(4'd1, 32'h1000_0000, 8'd0, 3'd2);
    read_check(4'd1, 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid;
    int bseen = 0;
    aw_send(4'd7, 32'h200, 8'd7, 3'd2);
    for (int k = 0; k < 3; k++) w_beat(32'hE0 + k, 4'hF, 1'b0);
    ar_send(4'd4, 32'h10, 8'd7, 3'd2);
    rready = 1'b1;
    repeat (2) @(negedge clk);
    rready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b00000) begin
      errors++;
      $display("FAIL midreset_hold: ar/aw/w/rv/bv got %b required 00000",
               {arready, awready, wready, rvalid, bvalid});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
      errors++;
      $display("FAIL midreset_release: ar/aw/w/rv/bv got %b required 11000",
               {arready, awready, wready, rvalid, bvalid});
    end
    bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bvalid) bseen++;
      @(negedge clk);
    end
    bready = 1'b0;
    checks++;
    if (bseen != 0) begin
      errors++;
      $display("FAIL midreset_no_b: bvalid cycles got %0d required 0", bseen);
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(32'hE0 + k);
    ar_send(4'd5, 32'h200, 8'd2, 3'd2);
    read_check(4'd5, 2'b00, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_stall();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024 (power of two): number of 32-bit words in the internal array.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port arid  input  4  read burst ID.
REQ-005 SHALL have port araddr  input  32  read start byte address.
REQ-006 SHALL have port arlen  input  8  read beats minus one.
REQ-007 SHALL have port arsize  input  3  read beat size (log2 bytes).
REQ-008 SHALL have port arvalid  input  1  read address valid.
REQ-009 SHALL have port arready  output  1  read address accepted.
REQ-010 SHALL have port rid  output  4  read data ID.
REQ-011 SHALL have port rdata  output  32  read data.
REQ-012 SHALL have port rresp  output  2  read response.
REQ-013 SHALL have port rlast  output  1  final read beat.
REQ-014 SHALL have port rvalid  output  1  read data valid.
REQ-015 SHALL have port rready  input  1  master accepts read data.
REQ-016 SHALL have port awid  input  4  write burst ID.
REQ-017 SHALL have port awaddr  input  32  write start byte address.
REQ-018 SHALL have port awlen  input  8  write beats minus one.
REQ-019 SHALL have port awsize  input  3  write beat size.
REQ-020 SHALL have port awvalid  input  1  write address valid.
REQ-021 SHALL have port awready  output  1  write address accepted.
REQ-022 SHALL have port wid  input  4  write data ID (ignored).
REQ-023 SHALL have port wdata  input  32  write data.
REQ-024 SHALL have port wstrb  input  4  byte lane enables.
REQ-025 SHALL have port wlast  input  1  master's final write beat flag.
REQ-026 SHALL have port wvalid  input  1  write data valid.
REQ-027 SHALL have port wready  output  1  write data accepted.
REQ-028 SHALL have port bid  output  4  write response ID.
REQ-029 SHALL have port bresp  output  2  write response.
REQ-030 SHALL have port bvalid  output  1  write response valid.
REQ-031 SHALL have port bready  input  1  master accepts response.

Function
REQ-032 Read and write paths SHALL be independent FSMs, each one outstanding burst, running concurrently; INCR bursts only, word-addressed, index = addr[log2(MEM_WORDS)+1:2], upper bits aliased, index wraps at MEM_WORDS.
REQ-033 Read FSM R_IDLE: arready=1, rvalid=0; on arvalid&arready latch arid, index, beat counter=arlen, err=(arsize>2) -> R_BURST.
REQ-034 R_BURST: arready=0, rvalid=1, rdata=mem[index] (combinational), rid=latched, rresp=err?2'b10:2'b00, rlast=(counter==0); on rvalid&rready index+1, counter-1; final beat -> R_IDLE; earliest next arready = cycle after final handshake.
REQ-035 rvalid SHALL hold with rdata/rid/rlast stable while rready=0; rdata=0 when rvalid=0.
REQ-036 Write FSM W_IDLE: awready=1; on awvalid&awready latch awid, index, counter=awlen, err=(awsize>2) -> W_DATA.
REQ-037 W_DATA: wready=1; on wvalid&wready write each byte lane i where wstrb[i]=1 (skip write if err), index+1, counter-1; set err if wlast != (counter==0); after beat with counter==0 -> W_RESP regardless of wlast.
REQ-038 W_RESP: bvalid=1, bid=latched awid, bresp=err?2'b10:2'b00; on bready -> W_IDLE; awready/wready=0 outside their states.
REQ-039 Same-cycle read of a word being written SHALL return the old value; new value visible from next cycle.

Reset
REQ-040 While reset=1: both FSMs to IDLE, arready=awready=wready=rvalid=bvalid=0, rlast=0, rresp=bresp=0, rid=bid=0; first cycle after reset arready=awready=1.
REQ-041 Reset mid-burst SHALL abandon the burst with no further beats or response; memory contents SHALL NOT be reset; already-written beats retained.

Verification
REQ-042 AW addr 0x10 len 3 size 2, W 0xA0..0xA3 strb 0xF, wlast on 4th -> bvalid, bid=awid, bresp=00; AR same -> 4 beats 0xA0..0xA3, rlast on 4th only.
REQ-043 Write 0xFFFFFFFF then wstrb=4'b0101 data 0x11223344 same word -> read 0xFF22FF44.
REQ-044 Read burst with rready toggling 1/0 every cycle -> data/rlast stable while stalled, no beat lost or duplicated.
REQ-045 Write len 1 with wlast on beat 1 -> bresp=2'b10 after beat 2; arsize=3 read -> all beats rresp=2'b10.
REQ-046 Concurrent 8-beat read and write to overlapping words at index MEM_WORDS-2 -> index wraps to 0; old-value rule per REQ-039; reset asserted mid-burst -> rvalid/bvalid low next cycle, arready=1 after release.
